mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port memory between instruction fetch (read-only) and the MEM stage (read/write).
- Sequences each access through a req/ack handshake with the memory and returns data plus a one-cycle ready pulse to the winning requester.
- The pipeline stalls the requester whose req is high and whose ready is low.
- Includes a configurable arbitration policy and a bus timeout.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- DATA_PRIORITY, 1, 1 = data port always wins ties; 0 = round-robin on ties.
- TIMEOUT, 255, max wait cycles for memAck before abort (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifReq  in  1  fetch request; held with ifAddr stable until ifReady.
- ifAddr  in  ADDR_WIDTH  fetch address.
- ifData  out  DATA_WIDTH  fetched word, valid when ifReady.
- ifReady  out  1  one-cycle completion pulse for fetch.
- dReq  in  1  data request; held with dWrite/dAddr/dWData stable until dReady.
- dWrite  in  1  1 = store, 0 = load.
- dAddr  in  ADDR_WIDTH  data address.
- dWData  in  DATA_WIDTH  store data.
- dRData  out  DATA_WIDTH  load data, valid when dReady.
- dReady  out  1  one-cycle completion pulse for data.
- memReq  out  1  memory request, held until memAck.
- memWrite  out  1  memory write strobe, qualified by memReq.
- memAddr  out  ADDR_WIDTH  memory address.
- memWData  out  DATA_WIDTH  memory write data.
- memRData  in  DATA_WIDTH  memory read data, sampled with memAck.
- memAck  in  1  memory completion, one cycle.
- busError  out  1  sticky timeout flag.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE; memReq, memWrite, ifReady, dReady, busError = 0; memAddr, memWData, ifData, dRData = 0; lastGrant=IF; waitCnt=0.
- States: IDLE, FETCH, DATA, DONE.
- IDLE: sample dReq and ifReq.
  - Neither high: stay in IDLE.
  - One high: grant it.
  - Both high: if DATA_PRIORITY=1, grant data. If 0, grant the port other than lastGrant (so data wins first after reset).
  - On grant: latch address, write data and write flag into the mem* outputs; set memReq=1 from the next cycle; waitCnt=0; go to FETCH or DATA; record lastGrant.
  - A fetch grant always drives memWrite=0.
- FETCH/DATA: memReq, memAddr, memWData and memWrite stay stable.
  - memAck=1 at an edge: memReq=0 and memWrite=0 next cycle; capture memRData into ifData (FETCH) or dRData (DATA, loads only; stores leave dRData unchanged); pulse the matching ready for exactly one cycle; go to DONE.
  - No memAck: waitCnt++. When waitCnt reaches TIMEOUT-1 without ack: busError=1 (sticky until rst), memReq=0, pulse the matching ready with its data output = 0, go to DONE.
  - memAck in the same cycle as the timeout edge counts as a normal completion.
- DONE: no grant this cycle (the requester is still holding req while ready is high); unconditionally return to IDLE.
- Latency: request seen at edge N -> memReq high N+1..; memAck at edge N+k -> ready high during cycle after N+k; next grant earliest at the edge after DONE. Minimum 3 cycles per access with immediate ack; back-to-back throughput is 1 access per 4 cycles when memAck comes one cycle after memReq rises.
- memAck outside FETCH/DATA is ignored.
- ifReady and dReady are never high simultaneously.
- A req dropped mid-access is a protocol violation: the access still completes and ready still pulses.
- Reset mid-access: memReq drops immediately (async); the in-flight access is discarded with no ready pulse.

Test Plan:
- Single fetch: ifReq=1, ifAddr=0x00000040; memory acks 1 cycle after memReq with 0x8C220004 -> memAddr=0x40, memWrite=0; ifData=0x8C220004 with ifReady high exactly 1 cycle; next grant no earlier than the following cycle.
- Store: dReq=1, dWrite=1, dAddr=0x100, dWData=0xCAFEF00D; ack after 3 cycles -> memWrite=1, memWData=0xCAFEF00D held 3 cycles; dReady pulses once; dRData unchanged.
- Contention, DATA_PRIORITY=1: ifReq and dReq (load from 0x200) asserted together and held -> data served first; fetch served second; grant order D,I.
- Contention, DATA_PRIORITY=0: both requesters held continuously for 4 accesses -> grants alternate D,I,D,I.
- Timeout, TIMEOUT=4: fetch with memAck tied 0 -> memReq drops after 4 cycles; ifReady pulses with ifData=0; busError=1 and stays 1 through later successful accesses until rst.
- Async reset: assert rst 2 cycles into a pending data access -> memReq=0 immediately without waiting for a clock edge; no dReady pulse; after release the first request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory-side signals of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifReq;
  logic [ADDR_WIDTH-1:0] ifAddr;
  logic [DATA_WIDTH-1:0] ifData;
  logic                  ifReady;
  logic                  dReq;
  logic                  dWrite;
  logic [ADDR_WIDTH-1:0] dAddr;
  logic [DATA_WIDTH-1:0] dWData;
  logic [DATA_WIDTH-1:0] dRData;
  logic                  dReady;
  logic                  memReq;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWData;
  logic [DATA_WIDTH-1:0] memRData;
  logic                  memAck;
  logic                  busError;
  modport slave (
    input  ifReq, ifAddr, dReq, dWrite, dAddr, dWData, memRData, memAck,
    output ifData, ifReady, dRData, dReady, memReq, memWrite, memAddr, memWData, busError
  );
  modport master (
    output ifReq, ifAddr, dReq, dWrite, dAddr, dWData, memRData, memAck,
    input  ifData, ifReady, dRData, dReady, memReq, memWrite, memAddr, memWData, busError
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and the MEM stage
module mem_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
  state_t r_state, w_state;
  logic r_last_d, w_last_d;
  logic r_mem_req, w_mem_req;
  logic r_mem_write, w_mem_write;
  logic r_if_ready, w_if_ready;
  logic r_d_ready, w_d_ready;
  logic r_bus_error, w_bus_error;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_data, w_if_data;
  logic [DATA_WIDTH-1:0] r_d_rdata, w_d_rdata;
  logic [CW-1:0] r_wait, w_wait;
  logic w_grant_d, w_busy, w_timeout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_write <= 1'b0;
      r_if_ready  <= 1'b0;
      r_d_ready   <= 1'b0;
      r_bus_error <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_d_rdata   <= '0;
      r_wait      <= '0;
    end else begin
      r_state     <= w_state;
      r_last_d    <= w_last_d;
      r_mem_req   <= w_mem_req;
      r_mem_write <= w_mem_write;
      r_if_ready  <= w_if_ready;
      r_d_ready   <= w_d_ready;
      r_bus_error <= w_bus_error;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_if_data   <= w_if_data;
      r_d_rdata   <= w_d_rdata;
      r_wait      <= w_wait;
    end
  // Ties go to data unless round-robin, where the port not granted last wins
  always_comb begin
    w_state     = r_state;
    w_last_d    = r_last_d;
    w_mem_req   = r_mem_req;
    w_mem_write = r_mem_write;
    w_if_ready  = 1'b0;
    w_d_ready   = 1'b0;
    w_bus_error = r_bus_error;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_if_data   = r_if_data;
    w_d_rdata   = r_d_rdata;
    w_wait      = r_wait;
    w_grant_d   = bus.dReq && (!bus.ifReq || DATA_PRIORITY != 0 || !r_last_d);
    w_busy      = r_state == FETCH || r_state == DATA;
    w_timeout   = w_busy && !bus.memAck && r_wait == LAST;
    if (r_state == IDLE && (bus.dReq || bus.ifReq)) begin
      w_state     = w_grant_d ? DATA : FETCH;
      w_last_d    = w_grant_d;
      w_mem_req   = 1'b1;
      w_mem_write = w_grant_d && bus.dWrite;
      w_mem_addr  = w_grant_d ? bus.dAddr : bus.ifAddr;
      w_mem_wdata = w_grant_d ? bus.dWData : '0;
      w_wait      = '0;
    end else if (w_busy && (bus.memAck || w_timeout)) begin
      w_state     = DONE;
      w_mem_req   = 1'b0;
      w_mem_write = 1'b0;
      w_bus_error = r_bus_error || w_timeout;
      w_if_ready  = r_state == FETCH;
      w_d_ready   = r_state == DATA;
      if (r_state == FETCH) w_if_data = w_timeout ? '0 : bus.memRData;
      else if (w_timeout || !r_mem_write) w_d_rdata = w_timeout ? '0 : bus.memRData;
    end else if (w_busy) begin
      w_wait = r_wait + 1'b1;
    end else if (r_state == DONE) begin
      w_state = IDLE;
    end
  end
  assign bus.memReq   = r_mem_req;
  assign bus.memWrite = r_mem_write;
  assign bus.memAddr  = r_mem_addr;
  assign bus.memWData = r_mem_wdata;
  assign bus.ifData   = r_if_data;
  assign bus.ifReady  = r_if_ready;
  assign bus.dRData   = r_d_rdata;
  assign bus.dReady   = r_d_ready;
  assign bus.busError = r_bus_error;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized model checks
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(1), .TIMEOUT(4))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_PRIORITY(0), .TIMEOUT(4))
    dut_b (.clk(clk), .rst(rst), .bus(b));
  logic [31:0] memory [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int ack_delay = 0;
  bit resp_en = 1'b1;
  int req_total = 0;
  int wr_total = 0;
  int viol = 0;
  logic [31:0] last_addr = '0;
  bit p_if = 1'b0;
  bit p_d = 1'b0;
  function automatic logic [31:0] dflt(input logic [31:0] ad);
    return ad ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] ad);
    return ref_mem.exists(ad) ? ref_mem[ad] : dflt(ad);
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic chk_s(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask
  // Memory for port a: acks ack_delay cycles after memReq is seen
  initial begin
    int cnt;
    cnt = 0;
    a.memAck = 1'b0;
    a.memRData = '0;
    forever begin
      @(negedge clk);
      a.memAck = 1'b0;
      if (a.memReq && resp_en) begin
        if (cnt >= ack_delay) begin
          a.memAck = 1'b1;
          a.memRData = a.memWrite ? 32'hDEAD_0000 :
                       (memory.exists(a.memAddr) ? memory[a.memAddr] : dflt(a.memAddr));
          if (a.memWrite) memory[a.memAddr] = a.memWData;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end
  initial begin
    b.memAck = 1'b0;
    b.memRData = '0;
    forever begin
      @(negedge clk);
      b.memAck = b.memReq;
      b.memRData = b.memAddr ^ 32'h0F0F_0F0F;
    end
  end
  always @(negedge clk) begin
    if (a.memReq) begin
      req_total++;
      last_addr = a.memAddr;
      if (a.memWrite && a.memWData == a.dWData) wr_total++;
    end
    if ((a.ifReady && a.dReady) || (a.ifReady && p_if) || (a.dReady && p_d)) viol++;
    p_if = a.ifReady;
    p_d = a.dReady;
  end
  task automatic xact(input bit di, input bit dd, input bit wr, input logic [31:0] ia,
                      input logic [31:0] da, input logic [31:0] wd, input int dly,
                      output logic [31:0] idat, output logic [31:0] ddat,
                      output string ord, output int rc, output int wc);
    int r0, w0;
    @(negedge clk);
    ack_delay = dly;
    r0 = req_total;
    w0 = wr_total;
    a.ifReq = di; a.ifAddr = ia;
    a.dReq = dd; a.dWrite = wr; a.dAddr = da; a.dWData = wd;
    ord = ""; idat = '0; ddat = '0;
    for (int n = 0; n < 60 && (a.ifReq || a.dReq); n++) begin
      @(negedge clk);
      if (a.ifReady) begin idat = a.ifData; ord = {ord, "I"}; a.ifReq = 1'b0; end
      if (a.dReady) begin ddat = a.dRData; ord = {ord, "D"}; a.dReq = 1'b0; end
    end
    if (a.ifReq || a.dReq) begin ord = {ord, "T"}; a.ifReq = 1'b0; a.dReq = 1'b0; end
    rc = req_total - r0;
    wc = wr_total - w0;
  endtask
  typedef struct {
    bit di, dd, wr;
    logic [31:0] ia, da, wd;
    int dly;
    string ord;
    logic [31:0] ei, ed, ea;
    int rc, wc;
  } vec_t;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end
  initial begin
    vec_t v [5];
    logic [31:0] idat, ddat, exp_i, exp_d, ia, da, wd;
    string ord, exp_ord;
    int rc, wc, np, cyc, mode, dly;
    int t [3];
    bit di, dd, wr, seen;
    a.ifReq = 0; a.ifAddr = 0; a.dReq = 0; a.dWrite = 0; a.dAddr = 0; a.dWData = 0;
    b.ifReq = 0; b.ifAddr = 32'h80; b.dReq = 0; b.dWrite = 0; b.dAddr = 32'h90; b.dWData = 0;
    memory[32'h40] = 32'h8C22_0004;
    memory[32'h200] = 32'h1234_5678;
    v[0] = '{1, 0, 0, 32'h40, 32'h0, 32'h0, 1, "I", 32'h8C22_0004, 32'h0, 32'h40, 2, 0};
    v[1] = '{0, 1, 1, 32'h0, 32'h100, 32'hCAFE_F00D, 2, "D", 32'h0, 32'h0, 32'h100, 3, 3};
    v[2] = '{0, 1, 0, 32'h0, 32'h100, 32'h0, 0, "D", 32'h0, 32'hCAFE_F00D, 32'h100, 1, 0};
    v[3] = '{1, 1, 0, 32'h40, 32'h200, 32'h0, 1, "DI", 32'h8C22_0004, 32'h1234_5678, 32'h40, 4, 0};
    v[4] = '{1, 1, 1, 32'h44, 32'h44, 32'h0BAD_BEEF, 0, "DI", 32'h0BAD_BEEF, 32'h1234_5678, 32'h44, 2, 1};
    repeat (2) @(negedge clk);
    chk("rst_ctl_a", {a.memReq, a.memWrite, a.ifReady, a.dReady, a.busError}, 0);
    chk("rst_addr_a", a.memAddr, 0);
    chk("rst_wdata_a", a.memWData, 0);
    chk("rst_ifdata_a", a.ifData, 0);
    chk("rst_drdata_a", a.dRData, 0);
    chk("rst_ctl_b", {b.memReq, b.memWrite, b.ifReady, b.dReady, b.busError}, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      xact(v[k].di, v[k].dd, v[k].wr, v[k].ia, v[k].da, v[k].wd, v[k].dly, idat, ddat, ord, rc, wc);
      chk_s($sformatf("v%0d_order", k), ord, v[k].ord);
      if (v[k].di) chk($sformatf("v%0d_ifdata", k), idat, v[k].ei);
      if (v[k].dd) chk($sformatf("v%0d_drdata", k), ddat, v[k].ed);
      chk($sformatf("v%0d_memaddr", k), last_addr, v[k].ea);
      chk($sformatf("v%0d_req_cycles", k), rc, v[k].rc);
      chk($sformatf("v%0d_write_cycles", k), wc, v[k].wc);
    end
    chk("busError_clean", a.busError, 0);
    // Fetch held continuously with a one-cycle-late ack: one access per 4 cycles
    @(negedge clk);
    ack_delay = 1; a.ifAddr = 32'h40; a.ifReq = 1'b1; cyc = 0; np = 0; t = '{0, 0, 0};
    for (int n = 0; n < 60 && np < 3; n++) begin
      @(negedge clk);
      cyc++;
      if (a.ifReady) begin t[np] = cyc; np++; end
    end
    a.ifReq = 1'b0;
    chk("b2b_first", t[0], 3);
    chk("b2b_gap1", t[1] - t[0], 4);
    chk("b2b_gap2", t[2] - t[1], 4);
    resp_en = 1'b0;
    xact(1, 0, 0, 32'h80, 0, 0, 0, idat, ddat, ord, rc, wc);
    resp_en = 1'b1;
    chk_s("timeout_order", ord, "I");
    chk("timeout_ifdata", idat, 0);
    chk("timeout_req_cycles", rc, 4);
    chk("timeout_busError", a.busError, 1);
    xact(0, 1, 0, 0, 32'h100, 0, 1, idat, ddat, ord, rc, wc);
    chk("after_timeout_drdata", ddat, 32'hCAFE_F00D);
    chk("busError_sticky", a.busError, 1);
    @(negedge clk);
    b.ifReq = 1'b1; b.dReq = 1'b1; ord = "";
    for (int n = 0; n < 80 && ord.len() < 4; n++) begin
      @(negedge clk);
      if (b.ifReady) ord = {ord, "I"};
      if (b.dReady) ord = {ord, "D"};
    end
    b.ifReq = 1'b0; b.dReq = 1'b0;
    chk_s("rr_order", ord, "DIDI");
    // Reset lands between clock edges while a load waits for its ack
    @(negedge clk);
    resp_en = 1'b0; a.dReq = 1'b1; a.dWrite = 1'b0; a.dAddr = 32'h200;
    repeat (2) @(negedge clk);
    chk("pre_rst_memreq", a.memReq, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_memreq", a.memReq, 0);
    chk("async_busError", a.busError, 0);
    a.dReq = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | a.dReady;
    end
    chk("no_ready_after_rst", seen, 0);
    rst = 1'b0; resp_en = 1'b1;
    xact(1, 0, 0, 32'h40, 0, 0, 1, idat, ddat, ord, rc, wc);
    chk_s("post_rst_order", ord, "I");
    chk("post_rst_ifdata", idat, 32'h8C22_0004);
    exp_d = '0;
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      di = mode != 1; dd = mode != 0; wr = 1'($urandom_range(0, 1));
      ia = 32'h300 + 32'(4 * $urandom_range(0, 7));
      da = 32'h300 + 32'(4 * $urandom_range(0, 7));
      wd = $urandom; dly = int'($urandom_range(0, 2));
      if (dd && wr) ref_mem[da] = wd;
      if (dd && !wr) exp_d = ref_rd(da);
      exp_i = ref_rd(ia);
      exp_ord = (dd && di) ? "DI" : (dd ? "D" : "I");
      xact(di, dd, wr, ia, da, wd, dly, idat, ddat, ord, rc, wc);
      chk_s($sformatf("rnd%0d_order", it), ord, exp_ord);
      if (di) chk($sformatf("rnd%0d_ifdata", it), idat, exp_i);
      if (dd) chk($sformatf("rnd%0d_drdata", it), ddat, exp_d);
      chk($sformatf("rnd%0d_req_cycles", it), rc, (dly + 1) * (int'(di) + int'(dd)));
    end
    chk("rnd_busError", a.busError, 0);
    chk("ready_exclusive_pulse", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
